// File: rtl/register_file_mp_pkg.sv
// Shared defaults and byte-merge helper for the multi-port register file.
package register_file_mp_pkg;

  localparam int DEF_REG_NUM    = 32;
  localparam int DEF_REG_WIDTH  = 32;
  localparam int DEF_REG_ADDR_W = 5;
  localparam int DEF_READ_PORTS = 2;
  localparam int DEF_ZERO_REG   = 1;

  // Merge one byte lane: the new byte replaces the old one only when its enable is set.
  function automatic logic [7:0] merge_byte(input logic [7:0] old_b,
                                            input logic [7:0] new_b,
                                            input logic       be);
    return be ? new_b : old_b;
  endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Busy-bit scoreboard: set by reservations, cleared by load returns; busy_cnt registered.
// Latency: busy and busy_cnt update on the edge after the request; backpressure: none.
module regfile_scoreboard
  import register_file_mp_pkg::*;
#(
  parameter int REG_NUM    = DEF_REG_NUM,
  parameter int REG_ADDR_W = DEF_REG_ADDR_W,
  parameter int ZERO_REG   = DEF_ZERO_REG
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rsv_en,
  input  logic [REG_ADDR_W-1:0] rsv_addr,
  input  logic                  wb_en,
  input  logic [REG_ADDR_W-1:0] wb_addr,
  output logic [REG_NUM-1:0]    busy,
  output logic [REG_ADDR_W:0]   busy_cnt
);

  logic [REG_NUM-1:0]  busy_nxt;
  logic [REG_ADDR_W:0] cnt_nxt;

  // Reservation is applied after the clear so a same-cycle rsv+wb leaves the register busy.
  always_comb begin
    busy_nxt = busy;
    cnt_nxt  = '0;
    for (int i = 0; i < REG_NUM; i++) begin
      if (wb_en && wb_addr == REG_ADDR_W'(i))
        busy_nxt[i] = 1'b0;
      if (rsv_en && rsv_addr == REG_ADDR_W'(i) && !(ZERO_REG != 0 && i == 0))
        busy_nxt[i] = 1'b1;
      cnt_nxt = cnt_nxt + (REG_ADDR_W+1)'(busy_nxt[i]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy     <= '0;
      busy_cnt <= '0;
    end else begin
      busy     <= busy_nxt;
      busy_cnt <= cnt_nxt;
    end
  end

endmodule

// File: rtl/register_file_mp.sv
// Register file: N combinational read ports, two byte-enabled write ports (B wins per byte).
// Latency: reads 0 cycles, writes commit on clk; REGFILE_BYPASS_EN forwards same-cycle writes.
module register_file_mp
  import register_file_mp_pkg::*;
#(
  parameter int REG_NUM    = DEF_REG_NUM,
  parameter int REG_WIDTH  = DEF_REG_WIDTH,
  parameter int REG_ADDR_W = DEF_REG_ADDR_W,
  parameter int READ_PORTS = DEF_READ_PORTS,
  parameter int ZERO_REG   = DEF_ZERO_REG
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [READ_PORTS*REG_ADDR_W-1:0] rd_addr,
  output logic [READ_PORTS*REG_WIDTH-1:0]  rd_data,
  output logic [READ_PORTS-1:0]            rd_busy,
  input  logic                             wa_en,
  input  logic [REG_ADDR_W-1:0]            wa_addr,
  input  logic [REG_WIDTH/8-1:0]           wa_be,
  input  logic [REG_WIDTH-1:0]             wa_data,
  input  logic                             wb_en,
  input  logic [REG_ADDR_W-1:0]            wb_addr,
  input  logic [REG_WIDTH/8-1:0]           wb_be,
  input  logic [REG_WIDTH-1:0]             wb_data,
  input  logic                             rsv_en,
  input  logic [REG_ADDR_W-1:0]            rsv_addr,
  output logic [REG_ADDR_W:0]              busy_cnt
);

  localparam int NBYTES = REG_WIDTH / 8;

  logic [REG_WIDTH-1:0] regs [REG_NUM];
  logic [REG_NUM-1:0]   busy;

  // Readable/writable: in range and not the hardwired zero register.
  function automatic logic addr_live(input logic [REG_ADDR_W-1:0] a);
    return ({1'b0, a} < (REG_ADDR_W+1)'(REG_NUM)) && !(ZERO_REG != 0 && a == '0);
  endfunction

  regfile_scoreboard #(
    .REG_NUM    (REG_NUM),
    .REG_ADDR_W (REG_ADDR_W),
    .ZERO_REG   (ZERO_REG)
  ) u_scoreboard (
    .clk      (clk),
    .rst      (rst),
    .rsv_en   (rsv_en),
    .rsv_addr (rsv_addr),
    .wb_en    (wb_en),
    .wb_addr  (wb_addr),
    .busy     (busy),
    .busy_cnt (busy_cnt)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < REG_NUM; i++)
        regs[i] <= '0;
    end else begin
      for (int i = 0; i < REG_NUM; i++) begin
        if (!(ZERO_REG != 0 && i == 0)) begin
          for (int b = 0; b < NBYTES; b++)
            regs[i][b*8 +: 8] <= merge_byte(
              merge_byte(regs[i][b*8 +: 8], wa_data[b*8 +: 8],
                         wa_en && wa_addr == REG_ADDR_W'(i) && wa_be[b]),
              wb_data[b*8 +: 8],
              wb_en && wb_addr == REG_ADDR_W'(i) && wb_be[b]);
        end
      end
    end
  end

  always_comb begin
    logic [REG_ADDR_W-1:0] addr;
    logic [REG_WIDTH-1:0]  word;
    logic                  bsy;
    rd_data = '0;
    rd_busy = '0;
    addr    = '0;
    word    = '0;
    bsy     = 1'b0;
    for (int p = 0; p < READ_PORTS; p++) begin
      addr = rd_addr[p*REG_ADDR_W +: REG_ADDR_W];
      if (addr_live(addr)) begin
        word = regs[addr];
        bsy  = busy[addr];
`ifdef REGFILE_BYPASS_EN
        for (int b = 0; b < NBYTES; b++)
          word[b*8 +: 8] = merge_byte(
            merge_byte(word[b*8 +: 8], wa_data[b*8 +: 8],
                       wa_en && wa_addr == addr && wa_be[b]),
            wb_data[b*8 +: 8],
            wb_en && wb_addr == addr && wb_be[b]);
        if (wb_en && wb_addr == addr && !(rsv_en && rsv_addr == addr))
          bsy = 1'b0;
`endif
        rd_data[p*REG_WIDTH +: REG_WIDTH] = word;
        rd_busy[p]                        = bsy;
      end
    end
  end

endmodule

// File: tb/tb_register_file_mp.sv
// Directed, table-driven checks of register_file_mp at default parameters.
module tb_register_file_mp;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [9:0]  rd_addr;
  logic [63:0] rd_data;
  logic [1:0]  rd_busy;
  logic        wa_en, wb_en, rsv_en;
  logic [4:0]  wa_addr, wb_addr, rsv_addr;
  logic [3:0]  wa_be, wb_be;
  logic [31:0] wa_data, wb_data;
  logic [5:0]  busy_cnt;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  register_file_mp dut (
    .clk      (clk),
    .rst      (rst),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .rd_busy  (rd_busy),
    .wa_en    (wa_en),
    .wa_addr  (wa_addr),
    .wa_be    (wa_be),
    .wa_data  (wa_data),
    .wb_en    (wb_en),
    .wb_addr  (wb_addr),
    .wb_be    (wb_be),
    .wb_data  (wb_data),
    .rsv_en   (rsv_en),
    .rsv_addr (rsv_addr),
    .busy_cnt (busy_cnt)
  );

  typedef struct {
    logic [31:0] wa_en, wa_addr, wa_be, wa_data;
    logic [31:0] wb_en, wb_addr, wb_be, wb_data;
    logic [31:0] rsv_en, rsv_addr;
    logic [31:0] ra0, ra1;
    logic [31:0] ed0, ed1, eb0, eb1, ecnt;
  } vec_t;

  vec_t vecs [15];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic idle();
    wa_en = 1'b0; wa_addr = '0; wa_be = '0; wa_data = '0;
    wb_en = 1'b0; wb_addr = '0; wb_be = '0; wb_data = '0;
    rsv_en = 1'b0; rsv_addr = '0;
  endtask

  task automatic apply(input vec_t v, input int idx);
    @(negedge clk);
    wa_en = v.wa_en[0]; wa_addr = v.wa_addr[4:0]; wa_be = v.wa_be[3:0]; wa_data = v.wa_data;
    wb_en = v.wb_en[0]; wb_addr = v.wb_addr[4:0]; wb_be = v.wb_be[3:0]; wb_data = v.wb_data;
    rsv_en = v.rsv_en[0]; rsv_addr = v.rsv_addr[4:0];
    rd_addr = {v.ra1[4:0], v.ra0[4:0]};
    @(posedge clk); #1;
    idle();
    #1;
    chk($sformatf("v%0d rd_data0", idx), rd_data[31:0], v.ed0);
    chk($sformatf("v%0d rd_data1", idx), rd_data[63:32], v.ed1);
    chk($sformatf("v%0d rd_busy0", idx), 32'(rd_busy[0]), v.eb0);
    chk($sformatf("v%0d rd_busy1", idx), 32'(rd_busy[1]), v.eb1);
    chk($sformatf("v%0d busy_cnt", idx), 32'(busy_cnt), v.ecnt);
  endtask

  initial begin
    //          wa: en addr be data            wb: en addr be data              rsv    rd a0 a1  exp d0 d1                 b0 b1 cnt
    vecs[0]  = '{1, 5, 'hF, 'hDEADBEEF,      0, 0, 0, 0,                     0, 0,  5, 0,  'hDEADBEEF, 0,            0, 0, 0};
    vecs[1]  = '{0, 0, 0, 0,                 1, 5, 'h1, 'h11,                0, 0,  5, 7,  'hDEADBE11, 0,            0, 0, 0};
    vecs[2]  = '{1, 7, 'hF, 'hAAAAAAAA,      1, 7, 'h3, 'h55555555,          0, 0,  7, 5,  'hAAAA5555, 'hDEADBE11,   0, 0, 0};
    vecs[3]  = '{0, 0, 0, 0,                 0, 0, 0, 0,                     1, 3,  3, 4,  0, 0,                     1, 0, 1};
    vecs[4]  = '{0, 0, 0, 0,                 0, 0, 0, 0,                     1, 4,  3, 4,  0, 0,                     1, 1, 2};
    vecs[5]  = '{0, 0, 0, 0,                 1, 3, 'h1, 'h33,                0, 0,  3, 4,  'h33, 0,                  0, 1, 1};
    vecs[6]  = '{0, 0, 0, 0,                 1, 4, 'hF, 'h44,                1, 4,  4, 3,  'h44, 'h33,               1, 0, 1};
    vecs[7]  = '{0, 0, 0, 0,                 0, 0, 0, 0,                     1, 4,  4, 3,  'h44, 'h33,               1, 0, 1};
    vecs[8]  = '{1, 0, 'hF, 'hFFFFFFFF,      1, 0, 'hF, 'hFFFFFFFF,          1, 0,  0, 4,  0, 'h44,                  0, 1, 1};
    vecs[9]  = '{0, 0, 0, 0,                 1, 4, 0, 'hFFFFFFFF,            0, 0,  4, 0,  'h44, 0,                  0, 0, 0};
    vecs[10] = '{1, 9, 0, 'hFF,              0, 0, 0, 0,                     0, 0,  9, 5,  0, 'hDEADBE11,            0, 0, 0};
    vecs[11] = '{1, 10, 'hF, 'h11223344,     1, 10, 'hC, 'hAABBCCDD,         0, 0,  10, 7, 'hAABB3344, 'hAAAA5555,   0, 0, 0};
    vecs[12] = '{1, 31, 'hF, 'h31,           0, 0, 0, 0,                     1, 31, 31, 10, 'h31, 'hAABB3344,        1, 0, 1};
    vecs[13] = '{1, 31, 'h3, 'h1234,         0, 0, 0, 0,                     0, 0,  31, 3, 'h1234, 'h33,             1, 0, 1};
    vecs[14] = '{0, 0, 0, 0,                 1, 31, 'h2, 'hAB00,             0, 0,  31, 31, 'hAB34, 'hAB34,          0, 0, 0};

    rst = 1'b1;
    idle();
    rd_addr = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Reset state across every address.
    chk("reset busy_cnt", 32'(busy_cnt), 32'd0);
    for (int a = 0; a < 16; a++) begin
      rd_addr = {5'(2*a+1), 5'(2*a)};
      #1;
      chk($sformatf("reset rd_data r%0d", 2*a), rd_data[31:0], 32'd0);
      chk($sformatf("reset rd_data r%0d", 2*a+1), rd_data[63:32], 32'd0);
      chk($sformatf("reset rd_busy r%0d", 2*a), 32'(rd_busy[0]), 32'd0);
      chk($sformatf("reset rd_busy r%0d", 2*a+1), 32'(rd_busy[1]), 32'd0);
    end

    for (int i = 0; i < 15; i++)
      apply(vecs[i], i);

    // Same-cycle data forwarding (r9 holds 0 before this write).
    @(negedge clk);
    rd_addr = {5'd0, 5'd9};
    wb_en = 1'b1; wb_addr = 5'd9; wb_be = 4'hF; wb_data = 32'h12345678;
    #1;
    chk("bypass same-cycle data", rd_data[31:0], BYP ? 32'h12345678 : 32'h0);
    @(posedge clk); #1;
    idle();
    #1;
    chk("bypass next-cycle data", rd_data[31:0], 32'h12345678);

    // Same-cycle busy clear on load return.
    @(negedge clk);
    rsv_en = 1'b1; rsv_addr = 5'd20;
    rd_addr = {5'd0, 5'd20};
    @(posedge clk); #1;
    idle();
    #1;
    chk("r20 reserved busy", 32'(rd_busy[0]), 32'd1);
    chk("r20 reserved cnt", 32'(busy_cnt), 32'd1);
    @(negedge clk);
    wb_en = 1'b1; wb_addr = 5'd20; wb_be = 4'h0;
    #1;
    chk("bypass same-cycle busy", 32'(rd_busy[0]), BYP ? 32'd0 : 32'd1);
    @(posedge clk); #1;
    idle();
    #1;
    chk("r20 released busy", 32'(rd_busy[0]), 32'd0);
    chk("r20 released cnt", 32'(busy_cnt), 32'd0);

    // Asynchronous reset mid-cycle, with writes presented while it is held.
    @(negedge clk);
    rsv_en = 1'b1; rsv_addr = 5'd20;
    @(posedge clk); #1;
    idle();
    rd_addr = {5'd7, 5'd20};
    #1;
    chk("pre-reset cnt", 32'(busy_cnt), 32'd1);
    chk("pre-reset r7", rd_data[63:32], 32'hAAAA5555);
    #2;
    rst = 1'b1;
    #1;
    chk("async reset r7", rd_data[63:32], 32'd0);
    chk("async reset busy r20", 32'(rd_busy[0]), 32'd0);
    chk("async reset cnt", 32'(busy_cnt), 32'd0);
    wa_en = 1'b1; wa_addr = 5'd7; wa_be = 4'hF; wa_data = 32'hFFFFFFFF;
    rsv_en = 1'b1; rsv_addr = 5'd20;
    @(posedge clk); #1;
    rst = 1'b0;
    idle();
    #1;
    chk("write during reset r7", rd_data[63:32], 32'd0);
    chk("rsv during reset busy", 32'(rd_busy[0]), 32'd0);
    chk("rsv during reset cnt", 32'(busy_cnt), 32'd0);
    @(negedge clk);
    wa_en = 1'b1; wa_addr = 5'd7; wa_be = 4'hF; wa_data = 32'h77;
    @(posedge clk); #1;
    idle();
    #1;
    chk("resume write r7", rd_data[63:32], 32'h77);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
